// File: rtl/uart_rx_fifo_ctrl.sv
// Purpose: synchronise the UART receiver's byte-complete level, queue received bytes in a FIFO, expose data/status registers to the CPU.
// Latency: push 3 clk after rx_done is seen high (SYNC_STAGES + 1); CPU read data and rvalid 1 clk after cpu_re.
// Backpressure: read_ce drops once the FIFO holds DEPTH-1 bytes; a byte arriving while full is dropped and sets sticky overflow.
module uart_rx_fifo_ctrl #(
    parameter int DEPTH_LOG2  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_en,
    output logic        read_ce,
    input  logic        cpu_re,
    input  logic        cpu_sel,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic        irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2:0]   cnt_t;
    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
    localparam cnt_t CE_LIMIT = cnt_t'(DEPTH - 1);

    // Synchroniser chain, edge register and post-reset arming
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   edge_q, edge_d;
    logic                   armed_q, armed_d;

    // FIFO state
    logic [7:0] mem_q [DEPTH];
    ptr_t       wptr_q, wptr_d;
    ptr_t       rptr_q, rptr_d;
    cnt_t       count_q, count_d;
    logic       ovf_q, ovf_d;

    // Registered outputs
    logic        read_ce_q, read_ce_d;
    logic        irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;

    // Combinational helpers
    logic        rx_done_s;
    logic        push_evt;
    logic        pop;
    logic        push_acc;
    logic        ovf_set;
    logic        status_rd;
    logic        full;
    logic        empty;
    logic [4:0]  cnt5;
    logic [31:0] status_word;
    logic        mem_we;

    assign rx_done_s   = sync_q[SYNC_STAGES-1];
    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign cnt5        = 5'(count_q);
    assign status_word = {16'h0, 3'b0, cnt5, 5'b0, ovf_q, full, ~empty};

    // Next-state: edge detect, push/pop arbitration, overflow and CPU read data
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], rx_done};
        fill_d    = {fill_q[SYNC_STAGES-2:0], 1'b1};
        edge_d    = rx_done_s;
        // Only arm once the chain carries real samples and shows rx_done low,
        // so a level already high across reset is never taken as a new byte.
        armed_d   = armed_q | (fill_q[SYNC_STAGES-1] & ~rx_done_s);

        push_evt  = armed_q & rx_done_s & ~edge_q;
        pop       = cpu_re & ~cpu_sel & ~empty;
        // A simultaneous pop frees the slot, so a push at full still lands.
        push_acc  = push_evt & (~full | pop);
        ovf_set   = push_evt & full & ~pop;
        status_rd = cpu_re & cpu_sel;

        mem_we    = push_acc;
        wptr_d    = push_acc ? wptr_q + 1'b1 : wptr_q;
        rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
        count_d   = count_q;
        if (push_acc && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_acc) begin
            count_d = count_q - 1'b1;
        end

        // Set beats the read-side clear when both hit in one cycle.
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (status_rd) begin
            ovf_d = 1'b0;
        end

        rdata_d = rdata_q;
        if (cpu_re) begin
            if (cpu_sel) begin
                rdata_d = status_word;
            end else if (!empty) begin
                rdata_d = {24'h0, mem_q[rptr_q]};
            end else begin
                rdata_d = 32'h0;
            end
        end
        rvalid_d  = cpu_re;

        // One entry of margin for the byte already in flight in the receiver.
        read_ce_d = rx_en & (count_q < CE_LIMIT);
        irq_d     = ~empty;
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            fill_q    <= '0;
            edge_q    <= 1'b0;
            armed_q   <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            read_ce_q <= 1'b0;
            irq_q     <= 1'b0;
            rdata_q   <= 32'h0;
            rvalid_q  <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            fill_q    <= fill_d;
            edge_q    <= edge_d;
            armed_q   <= armed_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            read_ce_q <= read_ce_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // FIFO storage; contents are meaningless once the pointers reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wptr_q] <= rx_data;
        end
    end

    assign read_ce    = read_ce_q;
    assign irq        = irq_q;
    assign cpu_rdata  = rdata_q;
    assign cpu_rvalid = rvalid_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Purpose: directed self-checking bench for uart_rx_fifo_ctrl.
// Latency: inputs driven on negedge, outputs sampled on negedge.
// Backpressure: read_ce level checked against FIFO fill level.
module tb_uart_rx_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_en = 1'b1;
    logic        read_ce;
    logic        cpu_re = 1'b0;
    logic        cpu_sel = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    uart_rx_fifo_ctrl #(.DEPTH_LOG2(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .rx_en      (rx_en),
        .read_ce    (read_ce),
        .cpu_re     (cpu_re),
        .cpu_sel    (cpu_sel),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full rx_done pulse: high 4 cycles (push on 3rd edge), low 3 cycles
    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        repeat (4) @(negedge clk);
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cpu_read(input logic sel, output logic [31:0] d, output logic v);
        @(negedge clk);
        cpu_re  = 1'b1;
        cpu_sel = sel;
        @(negedge clk);
        cpu_re  = 1'b0;
        d = cpu_rdata;
        v = cpu_rvalid;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        v;
        logic [7:0]  nb;
        int          chunk [3];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_rvalid", {31'h0, cpu_rvalid}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_read_ce", {31'h0, read_ce}, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("read_ce_idle", {31'h0, read_ce}, 32'h1);

        // Single byte
        @(negedge clk);
        rx_data = 8'hA5;
        rx_done = 1'b1;
        repeat (4) @(negedge clk);
        chk("irq_latency", {31'h0, irq}, 32'h1);
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        cpu_read(1'b1, d, v);
        chk("single_status", d, 32'h0000_0101);
        chk("single_status_vld", {31'h0, v}, 32'h1);
        cpu_read(1'b0, d, v);
        chk("single_data", d, 32'h0000_00A5);
        chk("single_data_vld", {31'h0, v}, 32'h1);
        @(negedge clk);
        chk("rvalid_pulse", {31'h0, cpu_rvalid}, 32'h0);
        chk("rdata_hold", cpu_rdata, 32'h0000_00A5);
        cpu_read(1'b1, d, v);
        chk("single_status_empty", d, 32'h0);

        // Empty read
        cpu_read(1'b0, d, v);
        chk("empty_data", d, 32'h0);
        chk("empty_vld", {31'h0, v}, 32'h1);
        cpu_read(1'b1, d, v);
        chk("empty_status", d, 32'h0);

        // Ordering and pointer wrap: 20 bytes in chunks of 6, 6, 8
        chunk[0] = 6; chunk[1] = 6; chunk[2] = 8;
        nb = 8'h00;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < chunk[c]; i++) push_byte(nb + 8'(i));
            for (int i = 0; i < chunk[c]; i++) begin
                cpu_read(1'b0, d, v);
                chk($sformatf("order_%02h", nb + 8'(i)), d, {24'h0, nb + 8'(i)});
            end
            nb = nb + 8'(chunk[c]);
        end
        cpu_read(1'b1, d, v);
        chk("order_drained", d, 32'h0);

        // Fill, read_ce threshold, overflow
        for (int i = 0; i < 14; i++) push_byte(8'h30 + 8'(i));
        chk("read_ce_at14", {31'h0, read_ce}, 32'h1);
        push_byte(8'h3E);
        chk("read_ce_at15", {31'h0, read_ce}, 32'h0);
        push_byte(8'h3F);
        cpu_read(1'b1, d, v);
        chk("full_status", d, 32'h0000_1003);
        push_byte(8'h55);
        cpu_read(1'b1, d, v);
        chk("ovf_status", d, 32'h0000_1007);
        cpu_read(1'b1, d, v);
        chk("ovf_cleared", d, 32'h0000_1003);
        cpu_read(1'b0, d, v);
        chk("full_first", d, 32'h0000_0030);
        push_byte(8'h40);
        cpu_read(1'b1, d, v);
        chk("refill_status", d, 32'h0000_1003);

        // Push event aligned with a data read at full
        @(negedge clk);
        rx_data = 8'h41;
        rx_done = 1'b1;
        repeat (2) @(negedge clk);
        cpu_re  = 1'b1;
        cpu_sel = 1'b0;
        @(negedge clk);
        cpu_re  = 1'b0;
        chk("simul_data", cpu_rdata, 32'h0000_0031);
        @(negedge clk);
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        cpu_read(1'b1, d, v);
        chk("simul_status", d, 32'h0000_1003);
        cpu_read(1'b0, d, v);
        chk("simul_next", d, 32'h0000_0032);

        // Reset mid-stream
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
        cpu_read(1'b1, d, v);
        chk("pre_rst_status", d, 32'h0000_0501);
        @(negedge clk);
        rx_data = 8'h77;
        rx_done = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("in_rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_irq", {31'h0, irq}, 32'h0);
        cpu_read(1'b1, d, v);
        chk("post_rst_status", d, 32'h0);
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        push_byte(8'h5A);
        cpu_read(1'b0, d, v);
        chk("post_rst_data", d, 32'h0000_005A);
        cpu_read(1'b1, d, v);
        chk("post_rst_final", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
